mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multi-cycle control unit for the MIPS datapath: a Moore state machine that sequences one shared memory, the register file and the ALU over several cycles per instruction, replacing the single-cycle combinational control. It sits beside the datapath, takes opcode/funct/zero and a memory ready handshake, and drives every datapath select and enable. It also keeps a retired-instruction counter for bench dumps.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read / mem_write  out  1  memory strobes
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load the instruction register
- pc_write  out  1  PC enable (unconditional or taken branch)
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1  register file write enable
- trap  out  1  illegal instruction, sticky until reset
- state_dbg  out  4  current state encoding
- instr_count  out  32  retired instructions

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12, JAL 13.
- FETCH: mem_read=1, iord=0, alu PC+4. Holds while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE: computes PC+(imm<<2) with ADD. Dispatches on opcode. 0x00 goes to R_EXEC. 0x23 and 0x2B go to MEM_ADDR. 0x04 and 0x05 go to BRANCH. 0x02 goes to JUMP. 0x08, 0x0A, 0x0C and 0x0D go to I_EXEC. Any other opcode goes to TRAP.
- R_EXEC: A op B. Funct mapping: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Any other funct goes to TRAP, not R_WB.
- R_WB: reg_dst=01, mem_to_reg=00, reg_write=1, then FETCH.
- MEM_ADDR: A + imm (ADD). Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_dst=00, mem_to_reg=01, reg_write=1.
- MEM_WR: mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- BRANCH: SUB of A and B, pc_src=01. pc_write = zero for beq, ~zero for bne. Then FETCH.
- JUMP: pc_src=10, pc_write=1, then FETCH.
- I_EXEC: alu_src_b=10. ALU op by opcode: 0x08 ADD, 0x0A SLT, 0x0C AND, 0x0D OR.
- I_WB: reg_dst=00, reg_write=1, then FETCH.
- TRAP: all enables 0, trap=1, stays in TRAP until rst.
- instr_count increments by 1 on every transition into FETCH from a non-FETCH state. It wraps 0xFFFFFFFF → 0. TRAP entries are not counted.
- Outputs not named for a state are 0 in that state.

## Timing
- Reset (async): state=FETCH, instr_count=0, trap=0. Outputs immediately take FETCH values: mem_read=1, alu_src_b=01, alu_ctrl=0010, everything else 0.
- Reset mid-instruction aborts it; mem_write drops combinationally on rst assertion.
- Outputs are Moore functions of state. The only exceptions are ir_write/pc_write (gated by mem_ready in FETCH) and pc_write in BRANCH (gated by zero).
- Latency with zero wait states: beq/bne/j 3 cycles; R-type, I-type and sw 4; lw 5; jal 3.
- Each cycle with mem_ready=0 during FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored in all other states.

## Configuration
- MIPS_MC_JAL_EN defined: opcode 0x03 goes from DECODE to JAL. JAL asserts reg_dst=10, mem_to_reg=10, reg_write=1, pc_src=10, pc_write=1, then FETCH.
- Not defined: 0x03 goes to TRAP and the JAL state does not exist in the RTL.

## Structure
- Package mips_mc_pkg holds:
  - state enum
  - opcode and funct localparams
  - alu_ctrl codes
  - mux select codes for pc_src, alu_src_b, reg_dst, mem_to_reg
- One combinational sub-module, mips_alu_decoder, maps (state class, opcode, funct) to alu_ctrl plus a funct_illegal flag.

## Test plan
- Reset then add (op 0x00, funct 0x20), mem_ready=1 → states 0,1,6,7,0. reg_write=1 only in R_WB with reg_dst=01. instr_count=1.
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD → 7-cycle instruction. mem_read/iord=1 held throughout MEM_RD. reg_write with mem_to_reg=01.
- beq (0x04): zero=1 → pc_write=1, pc_src=01 in BRANCH. bne (0x05) with zero=1 → pc_write=0. Both take 3 cycles.
- opcode 0x3F, and separately R-type funct 0x3F → TRAP. trap=1 held, no enables, instr_count unchanged, cleared only by rst.
- rst asserted during MEM_WR → mem_write falls the same timestep, state_dbg=0, instr_count=0.
- opcode 0x03 → with MIPS_MC_JAL_EN: reg_dst=10, mem_to_reg=10, pc_write=1, 3 cycles. Without the macro: TRAP.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg
//   Shared definitions for the multi-cycle MIPS control unit: FSM state
//   encoding, ALU operation class, opcode/funct values, ALU control codes
//   and datapath mux select codes.
//   Build option: MIPS_MC_JAL_EN adds the JAL state (encoding 13).
package mips_mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_I_EXEC   = 4'd10,
        ST_I_WB     = 4'd11,
        ST_TRAP     = 4'd12
`ifdef MIPS_MC_JAL_EN
        , ST_JAL    = 4'd13
`endif
    } state_e;

    // What the ALU is being used for in the current state.
    typedef enum logic [2:0] {
        AC_NONE  = 3'd0,
        AC_ADD   = 3'd1,
        AC_SUB   = 3'd2,
        AC_RTYPE = 3'd3,
        AC_ITYPE = 3'd4
    } alu_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder
//   Combinational ALU control decode.
//   Ports: alu_class (what the ALU is used for this state), opcode, funct
//   in; alu_ctrl (ALU operation) and funct_illegal (unknown R-type funct,
//   only raised for the R-type class) out.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  alu_class_e  alu_class,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_ctrl,
    output logic        funct_illegal
);

    // Select the ALU operation for the current ALU class.
    always_comb begin
        alu_ctrl      = ALU_AND;
        funct_illegal = 1'b0;
        case (alu_class)
            AC_ADD: alu_ctrl = ALU_ADD;
            AC_SUB: alu_ctrl = ALU_SUB;
            AC_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            AC_ITYPE: begin
                case (opcode)
                    OP_ADDI: alu_ctrl = ALU_ADD;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller
//   Moore multi-cycle control unit for the MIPS datapath. Sequences the
//   shared memory, register file and ALU; counts retired instructions.
//   Ports: clk, rst (async, active high); opcode, funct, zero, mem_ready in;
//   memory strobes, datapath selects/enables, trap, state_dbg and
//   instr_count out.
//   Build option: MIPS_MC_JAL_EN enables the jal (opcode 0x03) path;
//   without it 0x03 is illegal and traps.
module mips_mc_controller
    import mips_mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        trap,
    output logic [3:0]  state_dbg,
    output logic [31:0] instr_count
);

    state_e      state_r;
    state_e      state_next_s;
    alu_class_e  alu_class_s;
    logic        funct_illegal_s;
    logic [31:0] count_r;

    mips_alu_decoder u_alu_dec (
        .alu_class     (alu_class_s),
        .opcode        (opcode),
        .funct         (funct),
        .alu_ctrl      (alu_ctrl),
        .funct_illegal (funct_illegal_s)
    );

    // State register and retired-instruction counter; an instruction
    // retires when control returns to FETCH from any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FETCH;
            count_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if ((state_r != ST_FETCH) && (state_next_s == ST_FETCH)) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Next-state and Moore outputs; only FETCH (mem_ready) and BRANCH
    // (zero) gate an output on an input.
    always_comb begin
        state_next_s = state_r;
        alu_class_s  = AC_NONE;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_ALU;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        reg_dst      = DST_RT;
        mem_to_reg   = M2R_ALUOUT;
        reg_write    = 1'b0;
        trap         = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b   = SRCB_FOUR;
                alu_class_s = AC_ADD;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // Branch target computed speculatively while decoding.
                alu_src_b   = SRCB_IMM_SH2;
                alu_class_s = AC_ADD;
                case (opcode)
                    OP_RTYPE:                          state_next_s = ST_R_EXEC;
                    OP_LW, OP_SW:                      state_next_s = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_next_s = ST_BRANCH;
                    OP_J:                              state_next_s = ST_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next_s = ST_I_EXEC;
`ifdef MIPS_MC_JAL_EN
                    OP_JAL:                            state_next_s = ST_JAL;
`endif
                    default:                           state_next_s = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_class_s = AC_ADD;
                if (opcode == OP_SW) begin
                    state_next_s = ST_MEM_WR;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_next_s = ST_MEM_WB;
                end else begin
                    state_next_s = ST_MEM_RD;
                end
            end
            ST_MEM_WB: begin
                reg_dst      = DST_RT;
                mem_to_reg   = M2R_MDR;
                reg_write    = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_R_EXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_B;
                alu_class_s = AC_RTYPE;
                if (funct_illegal_s) begin
                    state_next_s = ST_TRAP;
                end else begin
                    state_next_s = ST_R_WB;
                end
            end
            ST_R_WB: begin
                reg_dst      = DST_RD;
                mem_to_reg   = M2R_ALUOUT;
                reg_write    = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_B;
                alu_class_s = AC_SUB;
                pc_src      = PC_SRC_ALUOUT;
                if (opcode == OP_BNE) begin
                    pc_write = ~zero;
                end else begin
                    pc_write = zero;
                end
                state_next_s = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src       = PC_SRC_JUMP;
                pc_write     = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_I_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_class_s  = AC_ITYPE;
                state_next_s = ST_I_WB;
            end
            ST_I_WB: begin
                reg_dst      = DST_RT;
                reg_write    = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_TRAP: begin
                trap         = 1'b1;
                state_next_s = ST_TRAP;
            end
`ifdef MIPS_MC_JAL_EN
            ST_JAL: begin
                reg_dst      = DST_RA;
                mem_to_reg   = M2R_PC;
                reg_write    = 1'b1;
                pc_src       = PC_SRC_JUMP;
                pc_write     = 1'b1;
                state_next_s = ST_FETCH;
            end
`endif
            // Unused encodings are treated as a fault and parked in TRAP.
            default: begin
                state_next_s = ST_TRAP;
            end
        endcase
    end

    assign state_dbg   = state_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller
//   Directed bench for mips_mc_controller. Each instruction is expanded
//   into its expected per-cycle state list (with wait states), and a
//   compare process checks every output and the retired count each cycle.
module tb_mips_mc_controller;

    localparam int S_FETCH = 0,  S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3;
    localparam int S_MEM_WB = 4, S_MEM_WR = 5, S_R_EXEC = 6,   S_R_WB = 7;
    localparam int S_BRANCH = 8, S_JUMP = 9,   S_I_EXEC = 10,  S_I_WB = 11;
    localparam int S_TRAP = 12,  S_JAL = 13;
`ifdef MIPS_MC_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic        alu_src_a, reg_write, trap;
    logic [3:0]  alu_ctrl, state_dbg;
    logic [31:0] instr_count;

    mips_mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .trap(trap), .state_dbg(state_dbg), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] st; logic mr; } cyc_t;
    typedef struct packed {
        logic mem_read, mem_write, iord, ir_write, pc_write;
        logic [1:0] pc_src; logic alu_src_a; logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl; logic [1:0] reg_dst, mem_to_reg;
        logic reg_write, trap;
    } out_t;

    int   total = 0;
    int   bad = 0;
    int   model_count = 0;
    cyc_t seq_q[$];
    cyc_t exp_cur;
    bit   exp_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input int st, input logic mr);
        cyc_t c;
        c.st = 4'(st);
        c.mr = mr;
        seq_q.push_back(c);
    endfunction

    function automatic void trap_tail();
        for (int i = 0; i < 4; i++) push(S_TRAP, rnd());
    endfunction

    // Expected state trace of one instruction: wf fetch waits, wm memory waits.
    function automatic void build_seq(input logic [5:0] op, input logic [5:0] fn,
                                      input int wf, input int wm);
        seq_q.delete();
        for (int i = 0; i < wf; i++) push(S_FETCH, 1'b0);
        push(S_FETCH, 1'b1);
        push(S_DECODE, rnd());
        case (op)
            6'h00: begin
                push(S_R_EXEC, rnd());
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                    push(S_R_WB, rnd());
                else
                    trap_tail();
            end
            6'h23: begin
                push(S_MEM_ADDR, rnd());
                for (int i = 0; i < wm; i++) push(S_MEM_RD, 1'b0);
                push(S_MEM_RD, 1'b1);
                push(S_MEM_WB, rnd());
            end
            6'h2B: begin
                push(S_MEM_ADDR, rnd());
                for (int i = 0; i < wm; i++) push(S_MEM_WR, 1'b0);
                push(S_MEM_WR, 1'b1);
            end
            6'h04, 6'h05: push(S_BRANCH, rnd());
            6'h02:        push(S_JUMP, rnd());
            6'h08, 6'h0A, 6'h0C, 6'h0D: begin
                push(S_I_EXEC, rnd());
                push(S_I_WB, rnd());
            end
            6'h03: begin
                if (JAL_EN) push(S_JAL, rnd());
                else trap_tail();
            end
            default: trap_tail();
        endcase
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h25: return 4'b0001;
            6'h2A: return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'h08: return 4'b0010;
            6'h0A: return 4'b0111;
            6'h0D: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Output table per state, straight from the state descriptions.
    function automatic out_t expect_for(input cyc_t c, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z);
        out_t o;
        o = '0;
        case (int'(c.st))
            S_FETCH:    begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_ctrl = 4'b0010;
                              o.ir_write = c.mr; o.pc_write = c.mr; end
            S_DECODE:   begin o.alu_src_b = 2'b11; o.alu_ctrl = 4'b0010; end
            S_MEM_ADDR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 4'b0010; end
            S_MEM_RD:   begin o.mem_read = 1'b1; o.iord = 1'b1; end
            S_MEM_WB:   begin o.mem_to_reg = 2'b01; o.reg_write = 1'b1; end
            S_MEM_WR:   begin o.mem_write = 1'b1; o.iord = 1'b1; end
            S_R_EXEC:   begin o.alu_src_a = 1'b1; o.alu_ctrl = r_alu(fn); end
            S_R_WB:     begin o.reg_dst = 2'b01; o.reg_write = 1'b1; end
            S_BRANCH:   begin o.alu_src_a = 1'b1; o.alu_ctrl = 4'b0110; o.pc_src = 2'b01;
                              o.pc_write = (op == 6'h05) ? !z : z; end
            S_JUMP:     begin o.pc_src = 2'b10; o.pc_write = 1'b1; end
            S_I_EXEC:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = i_alu(op); end
            S_I_WB:     begin o.reg_write = 1'b1; end
            S_TRAP:     begin o.trap = 1'b1; end
            S_JAL:      begin o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.reg_write = 1'b1;
                              o.pc_src = 2'b10; o.pc_write = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    // Per-cycle comparison of the DUT against the model, away from posedge.
    always @(negedge clk) begin
        out_t e;
        #2;
        if (exp_valid) begin
            e = expect_for(exp_cur, opcode, funct, zero);
            chk("state_dbg",   32'(state_dbg),   32'(exp_cur.st));
            chk("instr_count", instr_count,      32'(model_count));
            chk("mem_read",    32'(mem_read),    32'(e.mem_read));
            chk("mem_write",   32'(mem_write),   32'(e.mem_write));
            chk("iord",        32'(iord),        32'(e.iord));
            chk("ir_write",    32'(ir_write),    32'(e.ir_write));
            chk("pc_write",    32'(pc_write),    32'(e.pc_write));
            chk("pc_src",      32'(pc_src),      32'(e.pc_src));
            chk("alu_src_a",   32'(alu_src_a),   32'(e.alu_src_a));
            chk("alu_src_b",   32'(alu_src_b),   32'(e.alu_src_b));
            chk("alu_ctrl",    32'(alu_ctrl),    32'(e.alu_ctrl));
            chk("reg_dst",     32'(reg_dst),     32'(e.reg_dst));
            chk("mem_to_reg",  32'(mem_to_reg),  32'(e.mem_to_reg));
            chk("reg_write",   32'(reg_write),   32'(e.reg_write));
            chk("trap",        32'(trap),        32'(e.trap));
        end
    end

    task automatic do_reset();
        exp_valid = 1'b0;
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_state",     32'(state_dbg), 32'd0);
        chk("rst_count",     instr_count,    32'd0);
        chk("rst_trap",      32'(trap),      32'd0);
        chk("rst_mem_read",  32'(mem_read),  32'd1);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_alu_src_b", 32'(alu_src_b), 32'd1);
        chk("rst_alu_ctrl",  32'(alu_ctrl),  32'd2);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_count = 0;
    endtask

    // Drives one instruction cycle by cycle; limit truncates it (abort test).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm, input int limit);
        build_seq(op, fn, wf, wm);
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i < seq_q.size() && i < limit; i++) begin
            mem_ready = seq_q[i].mr;
            exp_cur   = seq_q[i];
            exp_valid = 1'b1;
            @(negedge clk);
        end
        exp_valid = 1'b0;
        if (limit >= seq_q.size() && int'(seq_q[seq_q.size()-1].st) != S_TRAP)
            model_count++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 99);             // add
        chk("add_len",   32'(seq_q.size()), 32'd4);
        chk("add_count", instr_count, 32'd1);
        run_instr(6'h00, 6'h22, 1'b0, 1, 0, 99);             // sub, 1 fetch wait
        run_instr(6'h00, 6'h24, 1'b0, 0, 0, 99);             // and
        run_instr(6'h00, 6'h25, 1'b0, 2, 0, 99);             // or
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0, 99);             // slt
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, 99);             // lw, 2 memory waits
        chk("lw_len", 32'(seq_q.size()), 32'd7);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 99);             // sw
        chk("sw_len", 32'(seq_q.size()), 32'd4);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 1, 99);             // sw, 1 memory wait
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, 99);             // beq taken
        chk("beq_len", 32'(seq_q.size()), 32'd3);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, 99);             // beq not taken
        run_instr(6'h05, 6'h00, 1'b1, 0, 0, 99);             // bne not taken
        chk("bne_len", 32'(seq_q.size()), 32'd3);
        run_instr(6'h05, 6'h00, 1'b0, 0, 0, 99);             // bne taken
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, 99);             // j
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, 99);             // addi
        run_instr(6'h0A, 6'h00, 1'b0, 0, 0, 99);             // slti
        run_instr(6'h0C, 6'h00, 1'b0, 0, 0, 99);             // andi
        run_instr(6'h0D, 6'h00, 1'b0, 0, 0, 99);             // ori
        chk("count_17", instr_count, 32'd17);

        run_instr(6'h03, 6'h00, 1'b0, 0, 0, 99);             // jal
        chk("jal_state", 32'(state_dbg), JAL_EN ? 32'd0 : 32'd12);
        chk("jal_count", instr_count,    JAL_EN ? 32'd18 : 32'd17);
        do_reset();

        run_instr(6'h08, 6'h00, 1'b0, 0, 0, 99);             // addi, count 1
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 99);             // illegal opcode
        chk("trap_held",  32'(trap),   32'd1);
        chk("trap_count", instr_count, 32'd1);
        do_reset();

        run_instr(6'h00, 6'h3F, 1'b0, 0, 0, 99);             // illegal funct
        chk("ftrap_state", 32'(state_dbg), 32'd12);
        do_reset();

        // Abort a store waiting on memory.
        run_instr(6'h2B, 6'h00, 1'b0, 0, 3, 4);
        chk("abort_pre_wr", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_wr",    32'(mem_write),   32'd0);
        chk("abort_state", 32'(state_dbg),   32'd0);
        chk("abort_count", instr_count,      32'd0);
        do_reset();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 99);             // add after abort

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
